tnet_tx_arbiter: RTL and testbench
==================================

# tnet_tx_arbiter

Frame-level round-robin arbiter that shares the single transport-to-net byte stream (`trans_tnet_*`) between several frame sources: UDP transmit, ARP reply/request, and ICMP echo. Once a source is granted, the grant is held until that source's `tlast` beat is accepted, so frames never interleave. An optional idle gap is enforced between frames. The block sits between the transport-layer transmitters and the MAC transmit path, in the `logic_clk` domain.

## Interface
Parameters:
- `N_SRC`, 3, number of requesting sources (2..8); index 0 = UDP, 1 = ARP, 2 = ICMP.
- `GAP_CYCLES`, 2, idle cycles forced after each frame's last beat (0..255; 0 = no gap).

Ports:
- `logic_clk`  in  1  clock.
- `logic_rst`  in  1  reset; one clock, reset synchronous and active-high.
- `src_tdata_in`  in  8*N_SRC  per-source byte; source i occupies bits [8i+7:8i].
- `src_tvalid_in`  in  N_SRC  per-source valid.
- `src_tlast_in`  in  N_SRC  per-source last beat of frame.
- `src_tready_out`  out  N_SRC  per-source ready.
- `trans_tnet_data_out`  out  8  arbitrated byte to net.
- `trans_tnet_valid_out`  out  1  arbitrated valid.
- `trans_tnet_last_out`  out  1  arbitrated last.
- `trans_tnet_ready_in`  in  1  downstream ready.
- `grant_out`  out  N_SRC  one-hot current owner; zero when not in XFER.
- `busy_out`  out  1  high in ARB, XFER or GAP.

## Operation
- FSM states: IDLE, ARB, XFER, GAP.
- IDLE: if any `src_tvalid_in` is set, go to ARB. No data moves.
- ARB: the round-robin pick among valid sources is registered into `grant`. The search starts at `last_grant+1` and wraps modulo `N_SRC`. Update `last_grant`, then go to XFER.
  - If no source is valid in ARB (a source dropped valid, which is a protocol violation tolerated here), return to IDLE without updating `last_grant`.
- XFER: data path is combinational pass-through from the granted source.
  - `trans_tnet_data/valid/last_out` = granted source's `tdata/tvalid/tlast`.
  - `src_tready_out[g]` = `trans_tnet_ready_in`; all other readies are 0.
  - When `valid & ready & last` are all high on the granted source, clear `grant` and go to GAP; if `GAP_CYCLES == 0`, go directly to IDLE.
- GAP: an 8-bit down-counter is loaded with `GAP_CYCLES-1` on entry. Return to IDLE when it reaches 0. All readies and output valid are 0.
- Non-granted sources are never acked. Their valid may stay high indefinitely, and they are served in round-robin turn.
- Fairness: with all sources continuously valid, grants cycle 0,1,2,0,… (for N_SRC=3).
- Reset values:
  - State IDLE, `grant` = 0, `last_grant` = N_SRC-1 (so source 0 wins first), gap counter 0.
  - All outputs 0: `src_tready_out`, `trans_tnet_valid_out`, `trans_tnet_last_out`, `grant_out`, `busy_out`. `trans_tnet_data_out` = 0.
- Reset mid-frame: the frame is truncated (no `tlast` is emitted). All outputs are 0 on the cycle after `logic_rst` is sampled high. Sources must also be reset.

## Timing
- Request to first beat:
  - IDLE sees valid at cycle t; ARB at t+1; XFER at t+2, where the first beat can be accepted.
  - Arbitration overhead is 2 cycles from IDLE.
- Throughput in XFER: 1 byte/cycle while the source is valid and downstream is ready. There is no added pipeline latency (zero-latency mux).
- Frame-to-frame spacing: after the last beat accepted at cycle t, the next frame's first beat is at t+GAP_CYCLES+3. With GAP_CYCLES=0 it is t+3.
- Backpressure: `trans_tnet_ready_in` low stalls only the granted source. State, grant and data stay stable.
- Single-beat frame (tlast on the first beat) is legal and exits XFER after 1 accepted beat.

## Structure
- Package `tnet_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, ARB, XFER, GAP} arb_state_t`.
  - Localparams `SRC_UDP=0`, `SRC_ARP=1`, `SRC_ICMP=2`.
- Sub-module `rr_pick`: combinational, parameter N.
  - Inputs: `req[N]`, `last[$clog2(N)]`.
  - Outputs: `gnt_idx`, `gnt_vld`.
  - Implements rotate, priority-encode, un-rotate.
- Top contains the FSM, gap counter, `grant`/`last_grant` registers and the output mux.

## Test plan
- **Single source:** UDP sends 5 bytes 0x11..0x15 with ready held high.
  - Required: bytes appear on `trans_tnet_*` in order, with last on 0x15.
  - `grant_out` = 3'b001 during the frame.
  - First beat 2 cycles after valid.
- **Simultaneous requests:** all 3 sources each present a 3-byte frame at the same cycle.
  - Required: serviced in order 0, 1, 2; no interleaving.
  - Each new first beat follows the previous last beat by GAP_CYCLES+3 = 5 cycles.
- **Round-robin rotation:** sources 0 and 2 continuously re-request 1-byte frames.
  - Required: grants alternate 0, 2, 0, 2; source 1 never granted; `src_tready_out[1]` stays 0.
- **Backpressure:** `trans_tnet_ready_in` toggles 1,0,0,1,… during a 4-byte ARP frame.
  - Required: exactly 4 beats transferred; data stable while ready is 0; `grant_out` = 3'b010 throughout.
- **GAP_CYCLES=0 build:** back-to-back frames from source 1, last at cycle t.
  - Required: next first beat at t+3; `busy_out` low for exactly 1 cycle (IDLE).
- **Reset mid-frame:** assert `logic_rst` at byte 3 of a 6-byte UDP frame.
  - Required: the next cycle has all outputs 0 and state IDLE.
  - After release, source 0 wins first again.

Source files
------------

// File: rtl/tnet_arb_pkg.sv
// tnet_arb_pkg: shared FSM state encoding and source indices for the tnet transmit arbiter
package tnet_arb_pkg;
  typedef enum logic [1:0] {IDLE, ARB, XFER, GAP} arb_state_t;
  localparam int SRC_UDP  = 0;
  localparam int SRC_ARP  = 1;
  localparam int SRC_ICMP = 2;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick (req, last in; gnt_idx, gnt_vld out), search starts at last+1 and wraps modulo N
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);
  localparam int W = $clog2(N);
  localparam logic [W:0] NW       = (W+1)'(N);
  localparam logic [W:0] LAST_IDX = (W+1)'(N-1);
  localparam logic [W:0] ONE      = (W+1)'(1);
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [W:0]     w_start;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_enc;
  assign w_dbl   = {req, req};
  assign w_start = {1'b0, last} == LAST_IDX ? '0 : {1'b0, last} + ONE;
  assign w_rot   = w_dbl[w_start +: N];
  always_comb begin
    w_enc = '0;
    for (int k = N-1; k >= 0; k--) w_enc = w_rot[k] ? W'(k) : w_enc;
  end
  assign w_sum   = {1'b0, w_enc} + w_start;
  assign gnt_idx = W'(w_sum >= NW ? w_sum - NW : w_sum);
  assign gnt_vld = |req;
endmodule

// File: rtl/tnet_tx_arbiter.sv
// tnet_tx_arbiter: frame-level round-robin mux of N_SRC byte streams (src_t*) onto trans_tnet_*, with grant_out/busy_out status
module tnet_tx_arbiter
  import tnet_arb_pkg::*;
#(
  parameter int N_SRC      = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic               logic_clk,
  input  logic               logic_rst,
  input  logic [8*N_SRC-1:0] src_tdata_in,
  input  logic [N_SRC-1:0]   src_tvalid_in,
  input  logic [N_SRC-1:0]   src_tlast_in,
  output logic [N_SRC-1:0]   src_tready_out,
  output logic [7:0]         trans_tnet_data_out,
  output logic               trans_tnet_valid_out,
  output logic               trans_tnet_last_out,
  input  logic               trans_tnet_ready_in,
  output logic [N_SRC-1:0]   grant_out,
  output logic               busy_out
);
  localparam int LW = $clog2(N_SRC);
  arb_state_t       r_state;
  logic [N_SRC-1:0] r_grant;
  logic [LW-1:0]    r_last_grant;
  logic [7:0]       r_gap;
  logic [LW-1:0]    w_pick_idx;
  logic             w_pick_vld;
  logic             w_xfer;
  logic             w_done;
  rr_pick #(.N(N_SRC)) u_pick (
    .req     (src_tvalid_in),
    .last    (r_last_grant),
    .gnt_idx (w_pick_idx),
    .gnt_vld (w_pick_vld)
  );
  // last_grant is updated on every successful pick, so it doubles as the owner index during XFER
  assign w_xfer               = r_state == XFER;
  assign trans_tnet_data_out  = w_xfer ? src_tdata_in[{r_last_grant, 3'b000} +: 8] : 8'h00;
  assign trans_tnet_valid_out = w_xfer & src_tvalid_in[r_last_grant];
  assign trans_tnet_last_out  = w_xfer & src_tlast_in[r_last_grant];
  assign src_tready_out       = r_grant & {N_SRC{trans_tnet_ready_in}};
  assign w_done               = trans_tnet_valid_out & trans_tnet_ready_in & trans_tnet_last_out;
  assign grant_out            = r_grant;
  assign busy_out             = r_state != IDLE;
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= LW'(N_SRC-1);
      r_gap        <= 8'd0;
    end else begin
      case (r_state)
        IDLE: r_state <= |src_tvalid_in ? ARB : IDLE;
        ARB: begin
          r_state <= w_pick_vld ? XFER : IDLE;
          if (w_pick_vld) begin
            r_grant      <= N_SRC'(1) << w_pick_idx;
            r_last_grant <= w_pick_idx;
          end
        end
        XFER: if (w_done) begin
          r_grant <= '0;
          r_state <= GAP_CYCLES == 0 ? IDLE : GAP;
          r_gap   <= 8'(GAP_CYCLES-1);
        end
        GAP: begin
          r_state <= r_gap == 8'd0 ? IDLE : GAP;
          r_gap   <= r_gap == 8'd0 ? 8'd0 : r_gap - 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tnet_tx_arbiter.sv
// tb_tnet_tx_arbiter: randomized and directed checks of tnet_tx_arbiter against a cycle-stamp reference model
module tb_tnet_tx_arbiter;
  localparam int N   = 3;
  localparam int GAP = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic           rst = 1'b1;
  logic [8*N-1:0] tdata = '0;
  logic [N-1:0]   tvalid = '0, tlast = '0, tready, ogrant;
  logic [7:0]     odata;
  logic           ovalid, olast, obusy;
  logic           ordy = 1'b0;
  logic           rst2 = 1'b1;
  logic [8*N-1:0] tdata2 = '0;
  logic [N-1:0]   tvalid2 = '0, tlast2 = '0, tready2, ogrant2;
  logic [7:0]     odata2;
  logic           ovalid2, olast2, obusy2;
  logic           rdy2 = 1'b1;
  tnet_tx_arbiter #(.N_SRC(N), .GAP_CYCLES(GAP)) dut (
    .logic_clk(clk), .logic_rst(rst), .src_tdata_in(tdata), .src_tvalid_in(tvalid),
    .src_tlast_in(tlast), .src_tready_out(tready), .trans_tnet_data_out(odata),
    .trans_tnet_valid_out(ovalid), .trans_tnet_last_out(olast), .trans_tnet_ready_in(ordy),
    .grant_out(ogrant), .busy_out(obusy)
  );
  tnet_tx_arbiter #(.N_SRC(N), .GAP_CYCLES(0)) dut_g0 (
    .logic_clk(clk), .logic_rst(rst2), .src_tdata_in(tdata2), .src_tvalid_in(tvalid2),
    .src_tlast_in(tlast2), .src_tready_out(tready2), .trans_tnet_data_out(odata2),
    .trans_tnet_valid_out(ovalid2), .trans_tnet_last_out(olast2), .trans_tnet_ready_in(rdy2),
    .grant_out(ogrant2), .busy_out(obusy2)
  );
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // source side: per-source frame queues of {last, byte}
  logic [8:0] sq [N][$];
  bit         hold [N];
  int         first_v [N];
  logic [N-1:0] hs = '0;
  bit  bubbles = 0;
  int  rmode = 0;
  int  pcnt = 0;
  // beats seen on the net side
  int         ob_cyc [$];
  logic [7:0] ob_dat [$];
  logic       ob_last [$];
  logic [N-1:0] ob_gnt [$];
  bit rdy1_seen = 0;
  // reference model: owner (-1 none), last owner, cycle arbitration happens, first cycle idle again
  bit m_on = 0;
  int m_owner = -1, m_last = N-1, m_arb = -1, m_idle_from = 0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_dl = '0;
  function automatic int rr(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last+k)%N]) return (last+k)%N;
    return -1;
  endfunction
  always @(negedge clk) begin
    logic [N-1:0] e_gnt;
    logic [7:0]   e_dat;
    logic         e_val, e_last, e_busy;
    hs = tready & tvalid;
    if (tready[1]) rdy1_seen = 1;
    if (m_on) begin
      e_gnt  = m_owner >= 0 ? N'(1) << m_owner : '0;
      e_val  = m_owner >= 0 && tvalid[m_owner];
      e_last = m_owner >= 0 && tlast[m_owner];
      e_dat  = m_owner >= 0 ? tdata[8*m_owner +: 8] : 8'h00;
      e_busy = m_owner >= 0 || cyc == m_arb || cyc < m_idle_from;
      chk("data_path", {odata, ovalid, olast}, {e_dat, e_val, e_last});
      chk("control", {tready, ogrant, obusy}, {e_gnt & {N{ordy}}, e_gnt, e_busy});
      if (prev_stall) chk("stall_hold", {olast, odata}, prev_dl);
      prev_stall = ovalid && !ordy && !rst;
      prev_dl = {olast, odata};
      if (ovalid && ordy) begin
        ob_cyc.push_back(cyc); ob_dat.push_back(odata); ob_last.push_back(olast); ob_gnt.push_back(ogrant);
      end
    end
    if (rst) begin
      m_on = 1; m_owner = -1; m_last = N-1; m_arb = -1; m_idle_from = cyc + 1; prev_stall = 1'b0;
    end else if (m_on) begin
      if (m_owner >= 0) begin
        if (tvalid[m_owner] && ordy && tlast[m_owner]) begin m_owner = -1; m_idle_from = cyc + 1 + GAP; end
      end else if (cyc == m_arb) begin
        m_arb = -1;
        m_owner = rr(tvalid, m_last);
        if (m_owner >= 0) m_last = m_owner; else m_idle_from = cyc + 1;
      end else if (cyc >= m_idle_from && |tvalid) m_arb = cyc + 1;
    end
  end
  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && sq[i].size() > 0) begin void'(sq[i].pop_front()); hold[i] = 0; end
      if (!hold[i] && sq[i].size() > 0 && (!bubbles || $urandom_range(3) != 0)) begin
        hold[i] = 1;
        if (first_v[i] < 0) first_v[i] = cyc;
      end
      tvalid[i] = hold[i];
      {tlast[i], tdata[8*i +: 8]} = sq[i].size() > 0 ? sq[i][0] : 9'h0;
    end
    ordy = rmode == 0 ? 1'b1 : rmode == 1 ? (pcnt % 3 == 0) : ($urandom_range(3) != 0);
    pcnt++;
  endtask
  task automatic clear_src();
    for (int i = 0; i < N; i++) begin sq[i].delete(); hold[i] = 0; end
  endtask
  task automatic clear_log();
    ob_cyc.delete(); ob_dat.delete(); ob_last.delete(); ob_gnt.delete();
    for (int i = 0; i < N; i++) first_v[i] = -1;
  endtask
  task automatic do_reset();
    rst = 1'b1; clear_src(); step(); rst = 1'b0;
  endtask
  function automatic bit pending();
    for (int i = 0; i < N; i++) if (sq[i].size() > 0) return 1;
    return m_owner >= 0 || m_arb >= 0 || cyc < m_idle_from;
  endfunction
  task automatic drain(input int budget);
    int k = 0;
    while (pending() && k < budget) begin step(); k++; end
    chk("drain_in_budget", k < budget, 1);
  endtask
  logic [8:0] q2 [$];
  int c2 [$], bc [$];
  logic [7:0] d2 [$];
  logic bb [$];
  initial begin
    int s, len, pushed, k, n_idle;
    logic acc;
    clear_log();
    step();
    do_reset();
    @(negedge clk);
    chk("reset_out", {odata, ovalid, olast, tready, ogrant, obusy}, 0);
    // single source
    clear_log(); rmode = 0; bubbles = 0;
    for (int b = 0; b < 5; b++) sq[0].push_back({b == 4, 8'h11 + 8'(b)});
    drain(100);
    chk("p1_beats", ob_dat.size(), 5);
    if (ob_dat.size() == 5) begin
      for (int b = 0; b < 5; b++) begin
        chk("p1_data", ob_dat[b], 8'h11 + 8'(b));
        chk("p1_last", ob_last[b], b == 4);
        chk("p1_grant", ob_gnt[b], 3'b001);
      end
      chk("p1_latency", ob_cyc[0] - first_v[0], 2);
    end
    // simultaneous requests
    do_reset(); clear_log();
    for (int i = 0; i < N; i++) for (int b = 0; b < 3; b++) sq[i].push_back({b == 2, 8'((i+1)*16 + b)});
    drain(200);
    chk("p2_beats", ob_dat.size(), 9);
    if (ob_dat.size() == 9) begin
      for (int j = 0; j < 9; j++) begin
        chk("p2_order", ob_gnt[j], N'(1) << (j/3));
        chk("p2_data", ob_dat[j], 8'((j/3+1)*16 + j%3));
      end
      chk("p2_spacing_a", ob_cyc[3] - ob_cyc[2], 5);
      chk("p2_spacing_b", ob_cyc[6] - ob_cyc[5], 5);
    end
    // rotation between sources 0 and 2
    clear_log(); rdy1_seen = 0;
    for (int b = 0; b < 4; b++) begin
      sq[0].push_back({1'b1, 8'h30 + 8'(b)});
      sq[2].push_back({1'b1, 8'h50 + 8'(b)});
    end
    drain(200);
    chk("p3_beats", ob_dat.size(), 8);
    if (ob_dat.size() == 8)
      for (int j = 0; j < 8; j++) chk("p3_grant", ob_gnt[j], j % 2 == 0 ? 3'b001 : 3'b100);
    chk("p3_rdy1_never", rdy1_seen, 0);
    // backpressure on an ARP frame
    clear_log(); rmode = 1; pcnt = 0;
    for (int b = 0; b < 4; b++) sq[1].push_back({b == 3, 8'h41 + 8'(b)});
    drain(200);
    chk("p4_beats", ob_dat.size(), 4);
    if (ob_dat.size() == 4)
      for (int j = 0; j < 4; j++) begin
        chk("p4_data", ob_dat[j], 8'h41 + 8'(j));
        chk("p4_grant", ob_gnt[j], 3'b010);
      end
    // reset in the middle of a UDP frame
    do_reset(); clear_log(); rmode = 0;
    for (int b = 0; b < 6; b++) sq[0].push_back({b == 5, 8'h61 + 8'(b)});
    k = 0;
    while (ob_dat.size() < 2 && k < 50) begin step(); k++; end
    chk("p5_reach_byte3", k < 50, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("p5_rst_out", {odata, ovalid, olast, tready, ogrant, obusy}, 0);
    clear_src();
    step();
    clear_log();
    for (int i = 0; i < N; i++) for (int b = 0; b < 2; b++) sq[i].push_back({b == 1, 8'h70 + 8'(i*2 + b)});
    drain(200);
    chk("p5_beats", ob_dat.size(), 6);
    if (ob_gnt.size() > 0) chk("p5_src0_first", ob_gnt[0], 3'b001);
    // random traffic with bubbles and random backpressure
    clear_log(); rmode = 2; bubbles = 1; pushed = 0;
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(5) == 0) begin
        s = $urandom_range(N-1);
        len = $urandom_range(5, 1);
        for (int b = 0; b < len; b++) sq[s].push_back({b == len-1, 8'($urandom)});
        pushed += len;
      end
      step();
    end
    drain(2000);
    chk("p6_beats", ob_dat.size(), pushed);
    // zero-gap build, back-to-back frames from source 1
    rst2 = 1'b0;
    q2 = {9'h071, 9'h172, 9'h073, 9'h174};
    for (int j = 0; j < 20; j++) begin
      tvalid2 = {1'b0, q2.size() > 0, 1'b0};
      {tlast2[1], tdata2[15:8]} = q2.size() > 0 ? q2[0] : 9'h0;
      @(negedge clk);
      acc = tready2[1] & tvalid2[1];
      if (acc) begin c2.push_back(cyc); d2.push_back(odata2); end
      bc.push_back(cyc); bb.push_back(obusy2);
      @(posedge clk); #1;
      if (acc) void'(q2.pop_front());
    end
    chk("g0_beats", c2.size(), 4);
    if (c2.size() == 4) begin
      chk("g0_data", {d2[0], d2[1], d2[2], d2[3]}, 32'h71727374);
      chk("g0_latency", c2[0] - bc[0], 2);
      chk("g0_spacing", c2[2] - c2[1], 3);
      n_idle = 0;
      for (int j = 0; j < bc.size(); j++) if (bc[j] > c2[1] && bc[j] < c2[2] && !bb[j]) n_idle++;
      chk("g0_idle_cycles", n_idle, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
